mpc_bound_table_dbuf: RTL and testbench
=======================================

// Module: mpc_bound_table_dbuf
// PURPOSE
//  Parametrised constraint-bound table for the dense MPC solver, with NUM_RD read ports.
//  Double-buffered: the solver reads the active bank while the host loads the shadow bank.
//  A swap request commits the shadow bank atomically, so bounds change only between solves.
//  Sits between the host/dSPACE bound-update path and the constraint-subtraction pipeline.
// PARAMETERS
//  DATA_W    21         entry width (signed fixed point)
//  ADDR_W    3          address width
//  DEPTH     8          entries per bank (DEPTH <= 2**ADDR_W)
//  NUM_RD    2          number of independent read ports
//  RD_LAT    1          read latency in cycles (1 or 2)
//  INIT_EVEN 21'h160000 reset value of even entries (both banks)
//  INIT_ODD  21'h19B781 reset value of odd entries (both banks)
// PORTS
//  clk         in  1              clock, rising edge
//  reset       in  1              asynchronous, active-low reset
//  rd_ce       in  NUM_RD         per-port read enable
//  rd_addr     in  NUM_RD*ADDR_W  per-port address (port p at [p*ADDR_W +: ADDR_W])
//  rd_data     out NUM_RD*DATA_W  per-port read data
//  rd_vld      out NUM_RD         rd_data valid, RD_LAT cycles after rd_ce
//  rd_oor      out NUM_RD         addr >= DEPTH at issue, aligned with rd_vld
//  ld_valid    in  1              shadow-bank write request
//  ld_ready    out 1              shadow-bank write accept
//  ld_addr     in  ADDR_W         shadow write address
//  ld_data     in  DATA_W         shadow write data
//  swap_req    in  1              one-cycle pulse: commit the shadow bank
//  swap_done   out 1              one-cycle pulse: swap committed
//  swap_err    out 1              one-cycle pulse: swap rejected (shadow incomplete)
//  shadow_full out 1              every shadow entry written since the last swap
//  bank_sel    out 1              index of the active bank
// BEHAVIOUR
//  Reset
//   - Both banks: INIT_EVEN at even addresses, INIT_ODD at odd addresses.
//   - bank_sel=0, written-bitmap=0.
//   - All rd_data, rd_vld, rd_oor, swap_done and swap_err = 0.
//   - Reset mid-load or mid-read discards everything in flight.
//  Read path
//   - Sample on rd_ce: address and bank_sel are captured in the issue cycle.
//   - Data reflects the bank active at issue, even if a swap commits during the pipeline.
//   - rd_data holds its value when rd_ce=0.
//   - Out-of-range address: rd_data=0 and rd_oor=1.
//   - Ports are fully independent; same-address reads on several ports are allowed.
//  Load path
//   - Write occurs when ld_valid && ld_ready; ld_ready is 1 except in the reset state.
//   - The write goes to bank !bank_sel and sets bitmap[ld_addr].
//   - Out-of-range ld_addr: accepted and dropped, bitmap unchanged.
//   - Rewriting an entry is allowed; the last write wins.
//  Swap
//   - On swap_req, evaluate bitmap_next = bitmap | write issued in the same cycle.
//   - The same-cycle write lands in the shadow bank before the swap.
//   - If bitmap_next is all ones over DEPTH: bank_sel toggles next edge, bitmap clears,
//     swap_done=1 for one cycle.
//   - Otherwise: no toggle, bitmap kept, swap_err=1 for one cycle.
//   - A read issued in the swap cycle uses the old bank; the next cycle uses the new bank.
//  Arithmetic: none; data is passed through unmodified at DATA_W.
// CONFIGURATION
//  MPC_BTAB_RDBACK_EN defined:
//   - Adds inputs hr_ce (1) and hr_addr (ADDR_W), and output hr_data (DATA_W).
//   - hr_data returns the shadow-bank entry 1 cycle later; reset value 0.
//   - Out-of-range hr_addr returns 0.
//  MPC_BTAB_RDBACK_EN undefined: these ports and their logic are absent.
// STRUCTURE
//  Shared package mpc_btab_pkg: DATA_W/ADDR_W defaults, INIT_EVEN/INIT_ODD,
//  and a function init_val(addr) that returns the reset value for an address.
//  Sub-module mpc_btab_rd_pipe: one read port (bank mux, RD_LAT stages, vld/oor),
//  instantiated NUM_RD times in a generate loop.
// TESTING
//  1. Reset, then read addresses 0..7 on both ports -> 160000/19B781 alternating;
//     rd_vld appears RD_LAT cycles after rd_ce.
//  2. Load 8 entries 0x000100+i, then swap_req -> swap_done, bank_sel=1;
//     the next read of address 3 returns 0x000103.
//  3. Load 7 entries, then swap_req -> swap_err, bank_sel unchanged;
//     load the 8th entry with swap_req in the same cycle -> swap_done.
//  4. RD_LAT=2: issue a read of address 5, then swap in the next cycle
//     -> old-bank value returned; the following read returns the new value.
//  5. Read address 9 with DEPTH=8 -> rd_data=0, rd_oor=1;
//     a load to address 9 -> bitmap unchanged.
//  6. Assert reset during a load burst -> defaults restored, bitmap=0,
//     rd_vld=0 on the next cycle.

Source files
------------

// File: rtl/mpc_btab_pkg.sv
// Shared definitions for the double-buffered MPC constraint-bound table:
// default widths, reset values of even/odd entries and swap status encoding.
package mpc_btab_pkg;

    localparam int BTAB_DATA_W = 21;
    localparam int BTAB_ADDR_W = 3;

    localparam logic [BTAB_DATA_W-1:0] BTAB_INIT_EVEN = 21'h160000;
    localparam logic [BTAB_DATA_W-1:0] BTAB_INIT_ODD  = 21'h19B781;

    // Registered outcome of a swap request, decoded into the two pulse outputs.
    typedef enum logic [1:0] {
        SWAP_IDLE = 2'd0,
        SWAP_DONE = 2'd1,
        SWAP_ERR  = 2'd2
    } swap_st_e;

    // Reset value of a table entry: even addresses and odd addresses differ.
    function automatic logic [BTAB_DATA_W-1:0] init_val(input int unsigned addr);
        return (addr % 2 == 0) ? BTAB_INIT_EVEN : BTAB_INIT_ODD;
    endfunction

endpackage

// File: rtl/mpc_btab_rd_pipe.sv
// One read port of the bound table: selects the active bank at issue time,
// flags out-of-range addresses and delays data/valid/oor by RD_LAT (1 or 2).
module mpc_btab_rd_pipe
    import mpc_btab_pkg::*;
#(
    parameter int DATA_W = BTAB_DATA_W,
    parameter int ADDR_W = BTAB_ADDR_W,
    parameter int DEPTH  = 8,
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_ce_i,
    input  logic [ADDR_W-1:0]       rd_addr_i,
    input  logic                    bank_sel_i,
    input  logic [DEPTH*DATA_W-1:0] bank0_i,
    input  logic [DEPTH*DATA_W-1:0] bank1_i,
    output logic [DATA_W-1:0]       rd_data_o,
    output logic                    rd_vld_o,
    output logic                    rd_oor_o
);

    logic              in_range;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] data1_q;
    logic              vld1_q;
    logic              oor1_q;

    // Decode the address against DEPTH and pick the entry from the active bank.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned; a missing default would infer a latch.
        in_range = 1'b0;
        sel_data = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (32'(rd_addr_i) == e) begin
                in_range = 1'b1;
                sel_data = bank_sel_i ? bank1_i[e*DATA_W +: DATA_W]
                                      : bank0_i[e*DATA_W +: DATA_W];
            end
        end
    end

    // Issue stage: capture data in the issue cycle so a later swap or shadow
    // write cannot alter an in-flight read; data holds while rd_ce is low.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            data1_q <= '0;
            vld1_q  <= 1'b0;
            oor1_q  <= 1'b0;
        end else begin
            vld1_q <= rd_ce_i;
            oor1_q <= rd_ce_i && !in_range;
            if (rd_ce_i) begin
                data1_q <= in_range ? sel_data : '0;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] data2_q;
        logic              vld2_q;
        logic              oor2_q;

        // Second pipeline stage; data only advances with a valid read.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                data2_q <= '0;
                vld2_q  <= 1'b0;
                oor2_q  <= 1'b0;
            end else begin
                vld2_q <= vld1_q;
                oor2_q <= oor1_q;
                if (vld1_q) begin
                    data2_q <= data1_q;
                end
            end
        end

        assign rd_data_o = data2_q;
        assign rd_vld_o  = vld2_q;
        assign rd_oor_o  = oor2_q;
    end else begin : g_lat1
        assign rd_data_o = data1_q;
        assign rd_vld_o  = vld1_q;
        assign rd_oor_o  = oor1_q;
    end

endmodule

// File: rtl/mpc_bound_table_dbuf.sv
// Double-buffered constraint-bound table for the dense MPC solver.
// The solver reads the active bank on NUM_RD independent ports while the host
// fills the shadow bank; a swap request commits the shadow bank atomically
// only when every entry has been written since the previous swap.
// Optional feature macro: MPC_BTAB_RDBACK_EN adds a host readback port
// (hr_ce/hr_addr/hr_data) onto the shadow bank.
module mpc_bound_table_dbuf
    import mpc_btab_pkg::*;
#(
    parameter int                DATA_W    = BTAB_DATA_W,
    parameter int                ADDR_W    = BTAB_ADDR_W,
    parameter int                DEPTH     = 8,
    parameter int                NUM_RD    = 2,
    parameter int                RD_LAT    = 1,
    parameter logic [DATA_W-1:0] INIT_EVEN = DATA_W'(init_val(0)),
    parameter logic [DATA_W-1:0] INIT_ODD  = DATA_W'(init_val(1))
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef MPC_BTAB_RDBACK_EN
    input  logic                     hr_ce,
    input  logic [ADDR_W-1:0]        hr_addr,
    output logic [DATA_W-1:0]        hr_data,
`endif
    input  logic [NUM_RD-1:0]        rd_ce,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_vld,
    output logic [NUM_RD-1:0]        rd_oor,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     swap_req,
    output logic                     swap_done,
    output logic                     swap_err,
    output logic                     shadow_full,
    output logic                     bank_sel
);

    logic [DEPTH*DATA_W-1:0] bank0_q;
    logic [DEPTH*DATA_W-1:0] bank1_q;
    logic                    bank_sel_q;
    logic                    bank_sel_d;
    logic [DEPTH-1:0]        bitmap_q;
    logic [DEPTH-1:0]        bitmap_d;
    logic [DEPTH-1:0]        bitmap_next;
    logic [DEPTH-1:0]        wr_mask;
    logic                    ld_ready_q;
    logic                    wr_fire;
    swap_st_e                swap_st_q;
    swap_st_e                swap_st_d;

    assign wr_fire = ld_valid && ld_ready_q;

    // One-hot write decode; out-of-range addresses produce an empty mask so the
    // write is accepted but dropped and the bitmap is untouched.
    always_comb begin
        wr_mask = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (wr_fire && (32'(ld_addr) == e)) begin
                wr_mask[e] = 1'b1;
            end
        end
    end

    // Swap decision: the write issued in the swap cycle counts toward a full
    // shadow bank, so a host can send the last entry together with swap_req.
    always_comb begin
        bitmap_next = bitmap_q | wr_mask;
        bank_sel_d  = bank_sel_q;
        bitmap_d    = bitmap_next;
        swap_st_d   = SWAP_IDLE;
        if (swap_req) begin
            if (&bitmap_next) begin
                bank_sel_d = ~bank_sel_q;
                bitmap_d   = '0;
                swap_st_d  = SWAP_DONE;
            end else begin
                swap_st_d  = SWAP_ERR;
            end
        end
    end

    // Control state: active bank, written-entry bitmap, swap status, load ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_sel_q <= 1'b0;
            bitmap_q   <= '0;
            swap_st_q  <= SWAP_IDLE;
            ld_ready_q <= 1'b0;
        end else begin
            bank_sel_q <= bank_sel_d;
            bitmap_q   <= bitmap_d;
            swap_st_q  <= swap_st_d;
            ld_ready_q <= 1'b1;
        end
    end

    // Table storage: host writes always target the shadow bank (!bank_sel).
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the banks are flops with an asynchronous reset because both
        // banks must power up holding the even/odd default bounds; a RAM
        // without reset could not provide that.
        if (!reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                bank0_q[e*DATA_W +: DATA_W] <= (e % 2 == 0) ? INIT_EVEN : INIT_ODD;
                bank1_q[e*DATA_W +: DATA_W] <= (e % 2 == 0) ? INIT_EVEN : INIT_ODD;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wr_mask[e]) begin
                    if (bank_sel_q) begin
                        bank0_q[e*DATA_W +: DATA_W] <= ld_data;
                    end else begin
                        bank1_q[e*DATA_W +: DATA_W] <= ld_data;
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        mpc_btab_rd_pipe #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH),
            .RD_LAT (RD_LAT)
        ) u_rd_pipe (
            .clk        (clk),
            .reset      (reset),
            .rd_ce_i    (rd_ce[p]),
            .rd_addr_i  (rd_addr[p*ADDR_W +: ADDR_W]),
            .bank_sel_i (bank_sel_q),
            .bank0_i    (bank0_q),
            .bank1_i    (bank1_q),
            .rd_data_o  (rd_data[p*DATA_W +: DATA_W]),
            .rd_vld_o   (rd_vld[p]),
            .rd_oor_o   (rd_oor[p])
        );
    end

`ifdef MPC_BTAB_RDBACK_EN
    logic [DATA_W-1:0] hr_sel;
    logic [DATA_W-1:0] hr_data_q;

    // Host readback mux onto the shadow bank; out-of-range reads return zero.
    always_comb begin
        hr_sel = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (32'(hr_addr) == e) begin
                hr_sel = bank_sel_q ? bank0_q[e*DATA_W +: DATA_W]
                                    : bank1_q[e*DATA_W +: DATA_W];
            end
        end
    end

    // Readback register: one cycle of latency, holds between requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hr_data_q <= '0;
        end else if (hr_ce) begin
            hr_data_q <= hr_sel;
        end
    end

    assign hr_data = hr_data_q;
`endif

    assign ld_ready    = ld_ready_q;
    assign swap_done   = (swap_st_q == SWAP_DONE);
    assign swap_err    = (swap_st_q == SWAP_ERR);
    assign shadow_full = &bitmap_q;
    assign bank_sel    = bank_sel_q;

endmodule

// File: tb/tb_mpc_bound_table_dbuf.sv
// Self-checking bench for mpc_bound_table_dbuf. Two instances share all inputs:
// dut2 uses RD_LAT=2 and dut1 uses RD_LAT=1; ADDR_W=4 so out-of-range
// addresses (>= DEPTH=8) can be driven.
module tb_mpc_bound_table_dbuf;

    localparam int DATA_W = 21;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 8;
    localparam int NUM_RD = 2;

    localparam logic [DATA_W-1:0] EVEN_V = 21'h160000;
    localparam logic [DATA_W-1:0] ODD_V  = 21'h19B781;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_RD-1:0]        rd_ce;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic                     ld_valid;
    logic [ADDR_W-1:0]        ld_addr;
    logic [DATA_W-1:0]        ld_data;
    logic                     swap_req;

    logic [NUM_RD*DATA_W-1:0] rd_data2, rd_data1;
    logic [NUM_RD-1:0]        rd_vld2, rd_vld1, rd_oor2, rd_oor1;
    logic ld_ready2, ld_ready1, swap_done2, swap_done1, swap_err2, swap_err1;
    logic shadow_full2, shadow_full1, bank_sel2, bank_sel1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mpc_bound_table_dbuf #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .RD_LAT(2)
    ) dut2 (
        .clk(clk), .reset(reset), .rd_ce(rd_ce), .rd_addr(rd_addr),
        .rd_data(rd_data2), .rd_vld(rd_vld2), .rd_oor(rd_oor2),
        .ld_valid(ld_valid), .ld_ready(ld_ready2), .ld_addr(ld_addr), .ld_data(ld_data),
        .swap_req(swap_req), .swap_done(swap_done2), .swap_err(swap_err2),
        .shadow_full(shadow_full2), .bank_sel(bank_sel2)
    );

    mpc_bound_table_dbuf #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .RD_LAT(1)
    ) dut1 (
        .clk(clk), .reset(reset), .rd_ce(rd_ce), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_vld(rd_vld1), .rd_oor(rd_oor1),
        .ld_valid(ld_valid), .ld_ready(ld_ready1), .ld_addr(ld_addr), .ld_data(ld_data),
        .swap_req(swap_req), .swap_done(swap_done1), .swap_err(swap_err1),
        .shadow_full(shadow_full1), .bank_sel(bank_sel1)
    );

    typedef struct {
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] e0;
        logic [DATA_W-1:0] e1;
        logic              o0;
        logic              o1;
    } rd_vec_t;

    rd_vec_t vt[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] pd(input logic [NUM_RD*DATA_W-1:0] v, input int p);
        return v[p*DATA_W +: DATA_W];
    endfunction

    // Issue one read on both ports, check dut1 one cycle later and dut2 two cycles later.
    task automatic rd_issue(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                            input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1,
                            input logic o0, input logic o1, input string tag);
        rd_ce   = 2'b11;
        rd_addr = {a1, a0};
        tick();
        rd_ce = 2'b00;
        check({tag, " lat1 p0 data"}, 32'(pd(rd_data1, 0)), 32'(e0));
        check({tag, " lat1 p1 data"}, 32'(pd(rd_data1, 1)), 32'(e1));
        check({tag, " lat1 vld"}, 32'(rd_vld1), 32'd3);
        check({tag, " lat1 oor"}, 32'(rd_oor1), 32'({o1, o0}));
        check({tag, " lat2 vld early"}, 32'(rd_vld2), 32'd0);
        tick();
        check({tag, " lat2 p0 data"}, 32'(pd(rd_data2, 0)), 32'(e0));
        check({tag, " lat2 p1 data"}, 32'(pd(rd_data2, 1)), 32'(e1));
        check({tag, " lat2 vld"}, 32'(rd_vld2), 32'd3);
        check({tag, " lat2 oor"}, 32'(rd_oor2), 32'({o1, o0}));
        check({tag, " lat1 vld drop"}, 32'(rd_vld1), 32'd0);
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic swap_pulse();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        rd_ce    = '0;
        rd_addr  = '0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        swap_req = 1'b0;

        // Reset state
        tick();
        check("rst ld_ready", 32'(ld_ready2), 32'd0);
        check("rst rd_vld", 32'({rd_vld2, rd_vld1}), 32'd0);
        check("rst rd_oor", 32'({rd_oor2, rd_oor1}), 32'd0);
        check("rst rd_data", 32'(pd(rd_data2, 0) | pd(rd_data1, 1)), 32'd0);
        check("rst bank_sel", 32'(bank_sel2), 32'd0);
        check("rst swap pulses", 32'({swap_done2, swap_err2}), 32'd0);
        check("rst shadow_full", 32'(shadow_full2), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("ld_ready after rst", 32'(ld_ready2), 32'd1);

        // Test 1: reset contents, table-driven
        for (int i = 0; i < 8; i++) begin
            vt[i].a0 = ADDR_W'(i);
            vt[i].a1 = ADDR_W'(7 - i);
            vt[i].e0 = (i % 2 == 0) ? EVEN_V : ODD_V;
            vt[i].e1 = ((7 - i) % 2 == 0) ? EVEN_V : ODD_V;
            vt[i].o0 = 1'b0;
            vt[i].o1 = 1'b0;
        end
        vt[8] = '{a0: 4'd9, a1: 4'd15, e0: '0, e1: '0, o0: 1'b1, o1: 1'b1};
        vt[9] = '{a0: 4'd8, a1: 4'd6, e0: '0, e1: EVEN_V, o0: 1'b1, o1: 1'b0};
        for (int i = 0; i < 10; i++) begin
            rd_issue(vt[i].a0, vt[i].a1, vt[i].e0, vt[i].e1, vt[i].o0, vt[i].o1,
                     $sformatf("t1 vec%0d", i));
        end

        // Test 2: full load then swap
        for (int i = 0; i < 8; i++) load(ADDR_W'(i), DATA_W'(32'h100 + i));
        check("t2 shadow_full", 32'(shadow_full2), 32'd1);
        check("t2 bank_sel before", 32'(bank_sel2), 32'd0);
        swap_pulse();
        check("t2 swap_done", 32'(swap_done2), 32'd1);
        check("t2 swap_err", 32'(swap_err2), 32'd0);
        check("t2 bank_sel", 32'(bank_sel2), 32'd1);
        check("t2 bank_sel lat1", 32'(bank_sel1), 32'd1);
        check("t2 shadow cleared", 32'(shadow_full2), 32'd0);
        tick();
        check("t2 swap_done pulse", 32'(swap_done2), 32'd0);
        rd_issue(4'd3, 4'd2, 21'h000103, 21'h000102, 1'b0, 1'b0, "t2 rd");

        // Test 3: incomplete shadow rejected, then last entry with swap
        for (int i = 0; i < 7; i++) load(ADDR_W'(i), DATA_W'(32'h200 + i));
        check("t3 shadow_full", 32'(shadow_full2), 32'd0);
        swap_pulse();
        check("t3 swap_err", 32'(swap_err2), 32'd1);
        check("t3 swap_done", 32'(swap_done2), 32'd0);
        check("t3 bank_sel kept", 32'(bank_sel2), 32'd1);
        tick();
        check("t3 swap_err pulse", 32'(swap_err2), 32'd0);
        ld_valid = 1'b1;
        ld_addr  = 4'd7;
        ld_data  = 21'h000207;
        swap_req = 1'b1;
        tick();
        ld_valid = 1'b0;
        swap_req = 1'b0;
        check("t3 same-cycle swap_done", 32'(swap_done2), 32'd1);
        check("t3 bank_sel", 32'(bank_sel2), 32'd0);
        rd_issue(4'd7, 4'd0, 21'h000207, 21'h000200, 1'b0, 1'b0, "t3 rd");

        // Test 4: swap while reads are in flight
        for (int i = 0; i < 8; i++) load(ADDR_W'(i), DATA_W'(32'h300 + i));
        rd_ce   = 2'b01;
        rd_addr = {4'd0, 4'd5};
        tick();
        check("t4 A lat1 p0", 32'(pd(rd_data1, 0)), 32'h205);
        rd_ce    = 2'b10;
        rd_addr  = {4'd5, 4'd0};
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("t4 B lat2 p0 old", 32'(pd(rd_data2, 0)), 32'h205);
        check("t4 B lat2 vld", 32'(rd_vld2), 32'd1);
        check("t4 B lat1 p1 swap-cycle", 32'(pd(rd_data1, 1)), 32'h205);
        check("t4 B swap_done", 32'(swap_done2), 32'd1);
        check("t4 B bank_sel", 32'(bank_sel2), 32'd1);
        rd_ce   = 2'b11;
        rd_addr = {4'd5, 4'd5};
        tick();
        rd_ce = 2'b00;
        check("t4 C lat2 p1 old", 32'(pd(rd_data2, 1)), 32'h205);
        check("t4 C lat2 vld", 32'(rd_vld2), 32'd2);
        check("t4 C lat1 p0 new", 32'(pd(rd_data1, 0)), 32'h305);
        check("t4 C lat1 p1 new", 32'(pd(rd_data1, 1)), 32'h305);
        tick();
        check("t4 D lat2 p0 new", 32'(pd(rd_data2, 0)), 32'h305);
        check("t4 D lat2 p1 new", 32'(pd(rd_data2, 1)), 32'h305);
        check("t4 D lat2 vld", 32'(rd_vld2), 32'd3);
        tick();
        check("t4 hold lat2 vld", 32'(rd_vld2), 32'd0);
        check("t4 hold lat2 p0", 32'(pd(rd_data2, 0)), 32'h305);
        check("t4 hold lat1 p1", 32'(pd(rd_data1, 1)), 32'h305);

        // Test 5: out-of-range read and load
        rd_issue(4'd9, 4'd12, '0, '0, 1'b1, 1'b1, "t5 oor rd");
        load(4'd0, 21'h000400);
        for (int i = 2; i < 8; i++) load(ADDR_W'(i), DATA_W'(32'h400 + i));
        load(4'd9, 21'h1FFFFF);
        check("t5 oor load no bit", 32'(shadow_full2), 32'd0);
        swap_pulse();
        check("t5 swap_err", 32'(swap_err2), 32'd1);
        check("t5 bank_sel kept", 32'(bank_sel2), 32'd1);
        load(4'd1, 21'h000401);
        check("t5 shadow_full", 32'(shadow_full2), 32'd1);
        swap_pulse();
        check("t5 swap_done", 32'(swap_done2), 32'd1);
        check("t5 bank_sel", 32'(bank_sel2), 32'd0);
        rd_issue(4'd1, 4'd0, 21'h000401, 21'h000400, 1'b0, 1'b0, "t5 rd");

        // Test 6: reset during a load burst with reads in flight
        for (int i = 0; i < 8; i++) load(ADDR_W'(i), DATA_W'(32'h500 + i));
        swap_pulse();
        check("t6 bank_sel pre", 32'(bank_sel2), 32'd1);
        load(4'd0, 21'h000600);
        ld_valid = 1'b1;
        ld_addr  = 4'd1;
        ld_data  = 21'h000601;
        rd_ce    = 2'b11;
        rd_addr  = {4'd1, 4'd0};
        tick();
        reset = 1'b0;
        #1;
        check("t6 rst rd_vld", 32'({rd_vld2, rd_vld1}), 32'd0);
        check("t6 rst rd_data", 32'(pd(rd_data1, 0)), 32'd0);
        check("t6 rst ld_ready", 32'(ld_ready2), 32'd0);
        check("t6 rst bank_sel", 32'(bank_sel2), 32'd0);
        check("t6 rst shadow_full", 32'(shadow_full2), 32'd0);
        ld_valid = 1'b0;
        rd_ce    = 2'b00;
        tick();
        reset = 1'b1;
        tick();
        check("t6 post rd_vld", 32'({rd_vld2, rd_vld1}), 32'd0);
        check("t6 post ld_ready", 32'(ld_ready2), 32'd1);
        rd_issue(4'd0, 4'd1, EVEN_V, ODD_V, 1'b0, 1'b0, "t6 rd");
        swap_pulse();
        check("t6 bitmap cleared", 32'(swap_err2), 32'd1);
        check("t6 bank_sel", 32'(bank_sel2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
